range_ctrl: RTL and testbench

User-side controller for the Collatz range engine on the DE1-SoC lab board. Debounces the pushbuttons, loads the start value from the switches, issues the `go`/`done` run handshake to the range engine, then walks the result read index `n` under button control. It also presents the engine's iteration `count` and the matching start-plus-offset value for the six-digit hex display. It sits between the board I/O in the top level and the range engine.

---
 rtl/range_ctrl.sv | 147 ++++++++++++++
 tb/tb_range_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/range_ctrl.sv
// rtl/range_ctrl.sv - key conditioning, run handshake and result index walk for the Collatz range engine.
// Optional macro: RANGE_CTRL_AUTOREPEAT_EN enables step auto-repeat while KEY[0]/KEY[1] is held in SHOW.
module range_ctrl #(
   parameter int RAM_WORDS       = 256,
   parameter int RAM_ADDR_BITS   = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  KEY,
   input  logic [9:0]  SW,
   input  logic        done,
   input  logic [15:0] count,
   output logic        go,
   output logic [31:0] start,
   output logic [11:0] n,
   output logic [11:0] disp_start,
   output logic [15:0] disp_count,
   output logic [9:0]  LEDR
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_GO, S_RUN, S_SHOW} state_t;

   state_t                   state;
   logic [3:0]               sync1, sync2, deb, press;
   logic [DB_W-1:0]          db_cnt [4];
   logic [RAM_ADDR_BITS-1:0] idx;
   logic                     rep_up, rep_dn;
   logic                     run_ev, clr_ev, up_ev, dn_ev;

   // The counter only runs while the synced level disagrees with the accepted level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         press <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= KEY;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt[i] <= '0;
               deb[i]    <= sync2[i];
               press[i]  <= ~sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef RANGE_CTRL_AUTOREPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] rep_cnt;
   logic            rep_again, rep_fire;

   // First repeat lands REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD.
   always_ff @(posedge clk) begin
      if (reset || state != S_SHOW || (deb[0] && deb[1]) || press[0] || press[1]) begin
         rep_cnt   <= '0;
         rep_again <= 1'b0;
         rep_fire  <= 1'b0;
      end else begin
         rep_fire <= 1'b0;
         if ((!rep_again && rep_cnt == RP_W'(REPEAT_DELAY - 2)) ||
             ( rep_again && rep_cnt == RP_W'(REPEAT_PERIOD - 1))) begin
            rep_fire  <= 1'b1;
            rep_again <= 1'b1;
            rep_cnt   <= '0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

   assign rep_up = rep_fire & ~deb[0];
   assign rep_dn = rep_fire & deb[0] & ~deb[1];
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   assign run_ev = press[3];
   assign clr_ev = press[2];
   assign up_ev  = press[0] | rep_up;
   assign dn_ev  = press[1] | rep_dn;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         go         <= 1'b0;
         start      <= '0;
         idx        <= '0;
         disp_count <= '0;
      end else begin
         go <= 1'b0;
         case (state)
            S_IDLE: begin
               idx        <= '0;
               disp_count <= '0;
               if (run_ev) begin
                  start <= {22'b0, SW};
                  go    <= 1'b1;
                  state <= S_GO;
               end
            end
            S_GO: state <= S_RUN;
            S_RUN: begin
               if (done) begin
                  idx   <= '0;
                  state <= S_SHOW;
               end
            end
            S_SHOW: begin
               disp_count <= count;
               if (run_ev) begin
                  start <= {22'b0, SW};
                  go    <= 1'b1;
                  state <= S_GO;
               end else if (clr_ev) begin
                  idx <= '0;
               end else if (up_ev) begin
                  idx <= idx + 1'b1;
               end else if (dn_ev) begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // idx is exactly RAM_ADDR_BITS wide, so the modulo-RAM_WORDS wrap is free.
   assign n          = 12'(idx);
   assign disp_start = start[11:0] + n;
   assign LEDR       = {n[7:0], state == S_SHOW, (state == S_GO) || (state == S_RUN)};
endmodule

// File: tb/tb_range_ctrl.sv
// tb/tb_range_ctrl.sv - scoreboard bench for range_ctrl with DEBOUNCE_CYCLES=4.
module tb_range_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  KEY = 4'hF;
   logic [9:0]  SW = '0;
   logic        done = 1'b0;
   logic [15:0] count = '0;
   logic        go;
   logic [31:0] start;
   logic [11:0] n;
   logic [11:0] disp_start;
   logic [15:0] disp_count;
   logic [9:0]  LEDR;

   typedef struct packed {
      logic        go;
      logic [1:0]  led;
      logic [11:0] n;
      logic [11:0] ds;
      logic [31:0] start;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   logic [13:0] prev_obs = '0;
   logic [13:0] obs_now;

   range_ctrl #(
      .RAM_WORDS(256), .RAM_ADDR_BITS(8), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .done(done), .count(count),
      .go(go), .start(start), .n(n), .disp_start(disp_start),
      .disp_count(disp_count), .LEDR(LEDR)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] f_count(input logic [11:0] idx);
      return 16'(idx) * 16'd3 + 16'd5;
   endfunction

   // Engine stand-in: count for the current n appears one cycle after n changes.
   always @(posedge clk) count <= f_count(n);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic g, input logic [1:0] led, input logic [11:0] nn, input logic [31:0] st);
      exp_t x;
      x.go = g; x.led = led; x.n = nn; x.ds = st[11:0] + nn; x.start = st;
      q.push_back(x);
   endtask

   task automatic tap(input logic [3:0] mask);
      @(posedge clk); #1 KEY = KEY & ~mask;
      repeat (10) @(posedge clk);
      #1 KEY = 4'hF;
      repeat (10) @(posedge clk);
   endtask

   task automatic pulse_done();
      @(posedge clk); #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
   endtask

   // Monitor: every go pulse or change of {state leds, n} must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         obs_now = {LEDR[1:0], n};
         if (go || obs_now != prev_obs) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: got go=%0d led=%b n=%0d expected none", go, LEDR[1:0], n);
            end else begin
               e = q.pop_front();
               chk("output_event", {5'b0, go, LEDR[1:0], n, disp_start, start}, {5'b0, e});
            end
         end
         prev_obs = obs_now;
      end
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_go", go, 0);
      chk("reset_start", start, 0);
      chk("reset_n", n, 0);
      chk("reset_disp_count", disp_count, 0);
      chk("reset_ledr", LEDR, 0);
      reset = 1'b0;
      prev_obs = '0;
      mon_en = 1'b1;

      // Run handshake with exact press-to-go latency.
      SW = 10'h01B;
      push(1'b1, 2'b01, 12'd0, 32'h1B);
      @(posedge clk); #1 KEY[3] = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("go_not_early", go, 0);
      @(posedge clk); #1;
      chk("go_latency", go, 1);
      chk("go_start", start, 32'h1B);
      chk("go_busy_led", LEDR[0], 1);
      @(posedge clk); #1 chk("go_one_cycle", go, 0);
      repeat (5) @(posedge clk);
      #1 KEY = 4'hF;
      repeat (12) @(posedge clk);
      push(1'b0, 2'b10, 12'd0, 32'h1B);
      pulse_done();
      chk("done_n", n, 0);
      chk("done_valid_led", LEDR[1], 1);
      repeat (4) @(posedge clk);
      #1 chk("disp_count_n0", disp_count, f_count(12'd0));

      // Wrap-around down, then two steps up.
      push(1'b0, 2'b10, 12'd255, 32'h1B);
      tap(4'b0010);
      chk("wrap_disp_start", disp_start, 12'h11A);
      chk("wrap_disp_count", disp_count, f_count(12'd255));
      push(1'b0, 2'b10, 12'd0, 32'h1B);
      tap(4'b0001);
      push(1'b0, 2'b10, 12'd1, 32'h1B);
      tap(4'b0001);
      chk("up_disp_count", disp_count, f_count(12'd1));

      // Bouncing key: 2-cycle toggles never settle, the final hold counts once.
      push(1'b0, 2'b10, 12'd2, 32'h1B);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 KEY[0] = ~KEY[0];
         @(posedge clk);
      end
      tap(4'b0001);
      chk("bounce_n", n, 2);

      // Clear beats up; run beats up.
      push(1'b0, 2'b10, 12'd0, 32'h1B);
      tap(4'b0101);
      SW = 10'h3FF;
      push(1'b1, 2'b01, 12'd0, 32'h3FF);
      tap(4'b1001);
      chk("run_reload_start", start, 32'h3FF);

      // Keys in RUN are ignored; reset mid-run returns to IDLE and a late done is ignored.
      tap(4'b0101);
      chk("run_keys_ignored", n, 0);
      push(1'b0, 2'b00, 12'd0, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pulse_done();
      tap(4'b0001);
      pulse_done();
      repeat (3) @(posedge clk);
      #1;
      chk("idle_n", n, 0);
      chk("idle_disp_count", disp_count, 0);
      chk("idle_ledr", LEDR, 0);

      // Held step key in SHOW.
      SW = 10'h005;
      push(1'b1, 2'b01, 12'd0, 32'h5);
      tap(4'b1000);
      push(1'b0, 2'b10, 12'd0, 32'h5);
      pulse_done();
`ifdef RANGE_CTRL_AUTOREPEAT_EN
      for (int i = 1; i <= 6; i++) push(1'b0, 2'b10, 12'(i), 32'h5);
`else
      push(1'b0, 2'b10, 12'd1, 32'h5);
`endif
      @(posedge clk); #1 KEY[0] = 1'b0;
      repeat (32) @(posedge clk);
      #1 KEY = 4'hF;
      repeat (20) @(posedge clk);

      #1 chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
